seq_shifter32: RTL and testbench

//  Multi-cycle 32-bit shift unit for the RV32I ALU: SLL, SRL, SRA by 0..31 bits.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/seq_shifter32_if.sv | 18 +
 rtl/seq_shifter32_step.sv | 24 ++
 rtl/seq_shifter32.sv | 90 +++++++++
 tb/tb_seq_shifter32.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions for the sequential shifter: widths, op codes and FSM states.
package alu_pkg;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = $clog2(WIDTH);

  localparam logic [1:0] SHIFT_SLL = 2'b00;
  localparam logic [1:0] SHIFT_SRL = 2'b01;
  localparam logic [1:0] SHIFT_SRA = 2'b10;
  localparam logic [1:0] SHIFT_RSV = 2'b11;

  localparam logic [SHAMT_W-1:0] CNT_ONE  = 5'd1;
  localparam logic [SHAMT_W-1:0] CNT_FOUR = 5'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  function automatic logic is_busy_state(input state_t st);
    return (st == ST_SHIFT) || (st == ST_DONE);
  endfunction

endpackage

// File: rtl/seq_shifter32_if.sv
// Request/response bundle between the control unit (master) and the shifter (slave).
interface seq_shifter32_if;
  import alu_pkg::*;

  logic               start;
  logic [1:0]         op;
  logic [WIDTH-1:0]   A;
  logic [SHAMT_W-1:0] shamt;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   O;

  modport master (output start, output op, output A, output shamt,
                  input busy, input done, input O);
  modport slave  (input start, input op, input A, input shamt,
                  output busy, output done, output O);

endinterface

// File: rtl/seq_shifter32_step.sv
// One shift step (by 1, or by 4 when by4 is set) with zero or sign fill per op.
module shift_step
  import alu_pkg::*;
(
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] din,
  input  logic             by4,
  output logic [WIDTH-1:0] dout
);

  // Select the shifted word for the latched op; reserved leaves the word untouched.
  always_comb begin
    dout = din;
    case (op)
      SHIFT_SLL: dout = by4 ? {din[WIDTH-5:0], 4'b0000} : {din[WIDTH-2:0], 1'b0};
      SHIFT_SRL: dout = by4 ? {4'b0000, din[WIDTH-1:4]} : {1'b0, din[WIDTH-1:1]};
      SHIFT_SRA: dout = by4 ? {{4{din[WIDTH-1]}}, din[WIDTH-1:4]}
                            : {din[WIDTH-1], din[WIDTH-1:1]};
      SHIFT_RSV: dout = din;
      default:   dout = din;
    endcase
  end

endmodule

// File: rtl/seq_shifter32.sv
// Multi-cycle SLL/SRL/SRA unit behind a start/busy/done handshake.
// Optional SEQ_SHIFT_STEP4_EN: steps by 4 while at least 4 bits remain.
module seq_shifter32
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  seq_shifter32_if.slave   sh
);

  state_t             r_state;
  state_t             w_state_next;
  logic [SHAMT_W-1:0] r_count;
  logic [SHAMT_W-1:0] w_count_next;
  logic [1:0]         r_op;
  logic [1:0]         w_op_next;
  logic [WIDTH-1:0]   r_o;
  logic [WIDTH-1:0]   w_o_next;
  logic [WIDTH-1:0]   w_step_out;
  logic               w_by4;
  logic               r_busy;
  logic               r_done;

`ifdef SEQ_SHIFT_STEP4_EN
  assign w_by4 = (r_count >= CNT_FOUR);
`else
  assign w_by4 = 1'b0;
`endif

  shift_step u_step (
    .op   (r_op),
    .din  (r_o),
    .by4  (w_by4),
    .dout (w_step_out)
  );

  // Next-state logic: inputs are only looked at in IDLE, so nothing queues while busy.
  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_op_next    = r_op;
    w_o_next     = r_o;
    case (r_state)
      ST_IDLE: begin
        if (sh.start) begin
          w_o_next     = sh.A;
          w_count_next = sh.shamt;
          w_op_next    = sh.op;
          w_state_next = ST_SHIFT;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (r_count != {SHAMT_W{1'b0}}) begin
          w_o_next     = w_step_out;
          w_count_next = r_count - (w_by4 ? CNT_FOUR : CNT_ONE);
        end else begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_count <= {SHAMT_W{1'b0}};
      r_op    <= SHIFT_SLL;
      r_o     <= {WIDTH{1'b0}};
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      r_op    <= w_op_next;
      r_o     <= w_o_next;
      r_busy  <= is_busy_state(w_state_next);
      r_done  <= (w_state_next == ST_DONE);
    end
  end

  assign sh.busy = r_busy;
  assign sh.done = r_done;
  assign sh.O    = r_o;

endmodule

// File: tb/tb_seq_shifter32.sv
// Self-checking bench for seq_shifter32: cycle-level reference model plus directed cases.
module tb_seq_shifter32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errs = 0;

  seq_shifter32_if bus();

  seq_shifter32 dut (.clk(clk), .reset(reset), .sh(bus));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_fn(input logic [1:0] op, input logic [31:0] a, input logic [4:0] s);
    case (op)
      2'd0:    return a << s;
      2'd1:    return a >> s;
      2'd2:    return $signed(a) >>> s;
      default: return a;
    endcase
  endfunction

  // Cycles from the accepting edge's cycle to the done cycle, inclusive of both ends' offset.
  function automatic int lat_fn(input logic [4:0] s);
`ifdef SEQ_SHIFT_STEP4_EN
    return int'(s) / 4 + int'(s) % 4 + 2;
`else
    return int'(s) + 2;
`endif
  endfunction

  // Reference model: m_left counts the edges still showing busy after an accepted start.
  int          m_left = 0;
  logic        m_live = 1'b0;
  logic        m_ok = 1'b0;
  logic [31:0] m_o = 32'd0;
  logic [31:0] m_res = 32'd0;

  always @(posedge clk) begin
    if (reset) begin
      m_live = 1'b1;
      m_left = 0;
      m_o    = 32'd0;
      m_ok   = 1'b1;
    end else if (m_left == 0) begin
      if (bus.start) begin
        m_left = lat_fn(bus.shamt);
        m_res  = ref_fn(bus.op, bus.A, bus.shamt);
        m_o    = bus.A;
        m_ok   = 1'b1;
      end
    end else begin
      m_left--;
      if (m_left == 1) begin
        m_o  = m_res;
        m_ok = 1'b1;
      end else if (m_left > 1) begin
        m_ok = 1'b0;
      end
    end
    #1;
    if (m_live) begin
      check("model_busy", {31'd0, bus.busy}, {31'd0, m_left > 0});
      check("model_done", {31'd0, bus.done}, {31'd0, m_left == 1});
      if (m_ok) check("model_O", bus.O, m_o);
    end
  end

  // Waits for idle, presents a request, and returns once it has been accepted.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [4:0] s, input bit hold);
    int n = 0;
    @(negedge clk);
    while (bus.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("idle_timeout", 32'd1, 32'd0);
    bus.start = 1'b1;
    bus.op    = op;
    bus.A     = a;
    bus.shamt = s;
    @(posedge clk);
    @(negedge clk);
    if (!hold) bus.start = 1'b0;
  endtask

  // Counts edges after the accepting edge until done; lat is the done cycle offset.
  task automatic wait_done(output logic [31:0] res, output int lat);
    int k = 0;
    res = 32'd0;
    lat = 0;
    while (k < 200) begin
      @(posedge clk);
      #2;
      k++;
      if (bus.done) break;
    end
    if (!bus.done) check("done_timeout", 32'd1, 32'd0);
    res = bus.O;
    lat = k + 1;
  endtask

  logic [31:0] res;
  int          lat;
  logic [31:0] avals [5] = '{32'h0000_0000, 32'h0000_0001, 32'h8000_0000, 32'hFFFF_FFFF, 32'hA5A5_5A5A};

  initial begin
    bus.start = 1'b0;
    bus.op    = 2'd0;
    bus.A     = 32'd0;
    bus.shamt = 5'd0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_O", bus.O, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // 1: reset in the middle of a 20-bit SLL
    issue(2'd0, 32'h0000_0001, 5'd20, 1'b0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #2;
    check("t1_busy", {31'd0, bus.busy}, 32'd0);
    check("t1_done", {31'd0, bus.done}, 32'd0);
    check("t1_O", bus.O, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    begin
      bit seen = 1'b0;
      repeat (30) begin
        @(posedge clk);
        #2;
        if (bus.done) seen = 1'b1;
      end
      check("t1_no_done", {31'd0, seen}, 32'd0);
    end

    // 2: longest SLL
    issue(2'd0, 32'h0000_0001, 5'd31, 1'b0);
    wait_done(res, lat);
    check("t2_O", res, 32'h8000_0000);
`ifdef SEQ_SHIFT_STEP4_EN
    check("t2_lat", 32'(lat), 32'd12);
`else
    check("t2_lat", 32'(lat), 32'd33);
`endif

    // 3: SRA versus SRL on a negative value
    issue(2'd2, 32'hF000_0000, 5'd4, 1'b0);
    wait_done(res, lat);
    check("t3_sra", res, 32'hFF00_0000);
    issue(2'd1, 32'hF000_0000, 5'd4, 1'b0);
    wait_done(res, lat);
    check("t3_srl", res, 32'h0F00_0000);

    // 4: zero shift amount
    issue(2'd2, 32'h8000_0001, 5'd0, 1'b0);
    wait_done(res, lat);
    check("t4_O", res, 32'h8000_0001);
    check("t4_lat", 32'(lat), 32'd2);

    // reserved op: count runs, data untouched
    issue(2'd3, 32'hA5A5_5A5A, 5'd7, 1'b0);
    wait_done(res, lat);
    check("rsv_O", res, 32'hA5A5_5A5A);
`ifdef SEQ_SHIFT_STEP4_EN
    check("rsv_lat", 32'(lat), 32'd6);
`else
    check("rsv_lat", 32'(lat), 32'd9);
`endif

    // 5: start held high, inputs changed while busy
    issue(2'd1, 32'hFFFF_FFFF, 5'd3, 1'b1);
    bus.A     = 32'h0000_0000;
    bus.op    = 2'd0;
    bus.shamt = 5'd5;
    wait_done(res, lat);
    check("t5_O", res, 32'h1FFF_FFFF);
    check("t5_lat", 32'(lat), 32'd5);
    @(posedge clk);
    #2;
    check("t5_done_cycle_ignored", {31'd0, bus.busy}, 32'd0);
    check("t5_O_held", bus.O, 32'h1FFF_FFFF);
    @(posedge clk);
    #2;
    check("t5_reaccept_busy", {31'd0, bus.busy}, 32'd1);
    check("t5_reaccept_O", bus.O, 32'h0000_0000);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(res, lat);
    check("t5_second_O", res, 32'h0000_0000);
`ifdef SEQ_SHIFT_STEP4_EN
    check("t5_second_lat", 32'(lat), 32'd4);
`else
    check("t5_second_lat", 32'(lat), 32'd7);
`endif

    // 6: sweep, results checked by the model, latency checked here
    foreach (avals[i]) begin
      for (int op = 0; op < 3; op++) begin
        for (int s = 0; s < 32; s++) begin
          issue(2'(op), avals[i], 5'(s), 1'b0);
          wait_done(res, lat);
          check("sweep_O", res, ref_fn(2'(op), avals[i], 5'(s)));
          check("sweep_lat", 32'(lat), 32'(lat_fn(5'(s))));
        end
      end
    end

    repeat (4) @(posedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
